// File: rtl/vend_pkg.sv
// Shared vending-machine definitions.
//   - coll_state_t : coin_collector transaction states
//   - DEFAULT_CURRENCY_WIDTH / DEFAULT_ITEM_ADDR_WIDTH : data widths shared
//     between coin_collector and output_logic
package vend_pkg;

  localparam int DEFAULT_CURRENCY_WIDTH  = 7;
  localparam int DEFAULT_ITEM_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REQUEST,
    ST_WAIT,
    ST_REFUND
  } coll_state_t;

endpackage : vend_pkg

// File: rtl/inactivity_timer.sv
// Inactivity timer for the coin collector.
// Counts enabled cycles since the last reload. 'expired' is high during the
// TIMEOUT_CYCLES-th consecutive enabled cycle after a reload; the owner
// decides whether to act on it.
// Ports:
//   clk     in  clock, rising edge
//   rstn    in  synchronous active-low reset
//   enable  in  count this cycle
//   reload  in  restart the count (wins over enable)
//   expired out timeout reached in this cycle (combinational from count)
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic reload,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (reload) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      // Saturate at LAST; the owner leaves the counting state on expiry.
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule : inactivity_timer

// File: rtl/coin_collector.sv
// Vending-machine transaction front end.
// Accumulates coin credit, latches the item selection, issues a one-cycle
// dispense request to output_logic, watches dispense_valid within a response
// window, and refunds credit on cancel or inactivity timeout.
// Ports (all outputs registered):
//   clk, rstn              clock / synchronous active-low reset
//   coin_valid, coin_value coin insertion strobe and value (0 is rejected)
//   select_valid, select_item  selection strobe and item address
//   cancel                 customer cancel strobe
//   dispense_valid         success indication from output_logic
//   dispense_enable        one-cycle dispense request
//   item_selected          latched item address
//   total_currency         accumulated credit
//   coin_accept/coin_reject coin outcome pulses
//   refund_valid/refund_amount refund pulse and held amount
//   busy                   high in REQUEST, WAIT and REFUND
module coin_collector
  import vend_pkg::*;
#(
  parameter int CURRENCY_WIDTH  = DEFAULT_CURRENCY_WIDTH,
  parameter int ITEM_ADDR_WIDTH = DEFAULT_ITEM_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int RESP_WINDOW     = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       coin_valid,
  input  logic [CURRENCY_WIDTH-1:0]  coin_value,
  input  logic                       select_valid,
  input  logic [ITEM_ADDR_WIDTH-1:0] select_item,
  input  logic                       cancel,
  input  logic                       dispense_valid,
  output logic                       dispense_enable,
  output logic [ITEM_ADDR_WIDTH-1:0] item_selected,
  output logic [CURRENCY_WIDTH-1:0]  total_currency,
  output logic                       coin_accept,
  output logic                       coin_reject,
  output logic                       refund_valid,
  output logic [CURRENCY_WIDTH-1:0]  refund_amount,
  output logic                       busy
);

  localparam int            WIN_W    = $clog2(RESP_WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RESP_WINDOW - 1);

  coll_state_t                state_q, state_d;
  logic [CURRENCY_WIDTH-1:0]  total_q, total_d;
  logic [ITEM_ADDR_WIDTH-1:0] item_q, item_d;
  logic [CURRENCY_WIDTH-1:0]  refund_amt_q, refund_amt_d;
  logic [WIN_W-1:0]           win_q, win_d;
  logic                       den_q, den_d;
  logic                       acc_q, acc_d;
  logic                       rej_q, rej_d;
  logic                       rv_q, rv_d;
  logic                       busy_q, busy_d;

  logic                       coin_add;
  logic                       timer_expired;
  logic [CURRENCY_WIDTH:0]    coin_sum;
  logic                       coin_fits;

  // One extra bit catches overflow; an overflowing or zero coin is returned
  // untouched rather than saturating or wrapping the credit.
  assign coin_sum  = {1'b0, total_q} + {1'b0, coin_value};
  assign coin_fits = !coin_sum[CURRENCY_WIDTH] && (coin_value != '0);

  // Held at zero outside COLLECT, so every entry (first coin or failed
  // dispense) starts a fresh timeout; accepted coins restart it as well.
  inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .enable (state_q == ST_COLLECT),
    .reload ((state_q != ST_COLLECT) || coin_add),
    .expired(timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    item_d       = item_q;
    refund_amt_d = refund_amt_q;
    win_d        = win_q;
    den_d        = 1'b0;
    rv_d         = 1'b0;
    coin_add     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (coin_valid && coin_fits) begin
          coin_add = 1'b1;
          total_d  = coin_sum[CURRENCY_WIDTH-1:0];
          state_d  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (cancel) begin
          state_d = ST_REFUND;
        end else if (select_valid && (total_q != '0)) begin
          item_d  = select_item;
          state_d = ST_REQUEST;
        end else if (coin_valid && coin_fits) begin
          coin_add = 1'b1;
          total_d  = coin_sum[CURRENCY_WIDTH-1:0];
        end else if (timer_expired) begin
          state_d = ST_REFUND;
        end
      end
      ST_REQUEST: begin
        den_d   = 1'b1;
        win_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dispense_valid) begin
          // Change is returned downstream, so the credit is simply consumed.
          total_d = '0;
          state_d = ST_IDLE;
        end else if (win_q == WIN_LAST) begin
          state_d = ST_COLLECT;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      ST_REFUND: begin
        rv_d         = 1'b1;
        refund_amt_d = total_q;
        total_d      = '0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any coin not added to the credit goes back to the customer.
    acc_d  = coin_add;
    rej_d  = coin_valid && !coin_add;
    busy_d = state_d inside {ST_REQUEST, ST_WAIT, ST_REFUND};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      total_q      <= '0;
      item_q       <= '0;
      refund_amt_q <= '0;
      win_q        <= '0;
      den_q        <= 1'b0;
      acc_q        <= 1'b0;
      rej_q        <= 1'b0;
      rv_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      item_q       <= item_d;
      refund_amt_q <= refund_amt_d;
      win_q        <= win_d;
      den_q        <= den_d;
      acc_q        <= acc_d;
      rej_q        <= rej_d;
      rv_q         <= rv_d;
      busy_q       <= busy_d;
    end
  end

  assign dispense_enable = den_q;
  assign item_selected   = item_q;
  assign total_currency  = total_q;
  assign coin_accept     = acc_q;
  assign coin_reject     = rej_q;
  assign refund_valid    = rv_q;
  assign refund_amount   = refund_amt_q;
  assign busy            = busy_q;

endmodule : coin_collector

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level reference model.
module tb_coin_collector;

  localparam int CW   = 7;
  localparam int IW   = 10;
  localparam int T    = 8;
  localparam int RW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          coin_valid = 1'b0;
  logic [CW-1:0] coin_value = '0;
  logic          select_valid = 1'b0;
  logic [IW-1:0] select_item = '0;
  logic          cancel = 1'b0;
  logic          dispense_valid = 1'b0;

  logic          dispense_enable;
  logic [IW-1:0] item_selected;
  logic [CW-1:0] total_currency;
  logic          coin_accept;
  logic          coin_reject;
  logic          refund_valid;
  logic [CW-1:0] refund_amount;
  logic          busy;

  coin_collector #(
    .CURRENCY_WIDTH (CW),
    .ITEM_ADDR_WIDTH(IW),
    .TIMEOUT_CYCLES (T),
    .RESP_WINDOW    (RW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .select_valid   (select_valid),
    .select_item    (select_item),
    .cancel         (cancel),
    .dispense_valid (dispense_valid),
    .dispense_enable(dispense_enable),
    .item_selected  (item_selected),
    .total_currency (total_currency),
    .coin_accept    (coin_accept),
    .coin_reject    (coin_reject),
    .refund_valid   (refund_valid),
    .refund_amount  (refund_amount),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model. A customer session is "open" whenever credit is held
  // and nothing is in flight; in-flight work is either a pending refund or
  // a dispense tracked by its age in cycles since the selection.
  // ---------------------------------------------------------------------
  localparam int M_FREE = 0, M_REFUND = 1, M_DISP = 2;

  int cyc = 0;
  int m_mode = M_FREE;
  int m_credit = 0, m_item = 0, m_ramt = 0, m_idle = 0, m_sel_cyc = 0;
  int m_acc = 0, m_rej = 0, m_rv = 0, m_den = 0;
  int age;

  always @(posedge clk) begin
    cyc++;
    m_acc = 0; m_rej = 0; m_rv = 0; m_den = 0;
    if (!rstn) begin
      m_credit = 0; m_item = 0; m_ramt = 0; m_idle = 0; m_mode = M_FREE;
    end else if (m_mode == M_REFUND) begin
      m_rej    = int'(coin_valid);
      m_rv     = 1;
      m_ramt   = m_credit;
      m_credit = 0;
      m_mode   = M_FREE;
    end else if (m_mode == M_DISP) begin
      m_rej = int'(coin_valid);
      age   = cyc - m_sel_cyc;
      if (age == 1) begin
        m_den = 1;
      end else if (dispense_valid) begin
        m_credit = 0;
        m_mode   = M_FREE;
      end else if (age == RW + 1) begin
        m_mode = M_FREE;
        m_idle = 0;
      end
    end else if (m_credit == 0) begin
      if (coin_valid) begin
        if (coin_value != 0) begin
          m_acc = 1; m_credit = int'(coin_value); m_idle = 0;
        end else begin
          m_rej = 1;
        end
      end
    end else begin
      if (cancel) begin
        m_rej  = int'(coin_valid);
        m_mode = M_REFUND;
      end else if (select_valid) begin
        m_rej     = int'(coin_valid);
        m_item    = int'(select_item);
        m_sel_cyc = cyc;
        m_mode    = M_DISP;
      end else if (coin_valid && coin_value != 0 && m_credit + int'(coin_value) <= MAXC) begin
        m_acc    = 1;
        m_credit = m_credit + int'(coin_value);
        m_idle   = 0;
      end else begin
        m_rej = int'(coin_valid);
        m_idle++;
        if (m_idle >= T) m_mode = M_REFUND;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("cmp_total",  32'(total_currency),  m_credit);
    check("cmp_item",   32'(item_selected),   m_item);
    check("cmp_ramt",   32'(refund_amount),   m_ramt);
    check("cmp_accept", 32'(coin_accept),     m_acc);
    check("cmp_reject", 32'(coin_reject),     m_rej);
    check("cmp_refund", 32'(refund_valid),    m_rv);
    check("cmp_den",    32'(dispense_enable), m_den);
    check("cmp_busy",   32'(busy),            int'(m_mode != M_FREE));
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: drive one cycle of inputs, return at the next negedge.
  // ---------------------------------------------------------------------
  task automatic step(input bit cv, input int val, input bit sv, input int it,
                      input bit can, input bit dv);
    coin_valid     = cv;
    coin_value     = CW'(val);
    select_valid   = sv;
    select_item    = IW'(it);
    cancel         = can;
    dispense_valid = dv;
    @(negedge clk);
  endtask

  task automatic idle();               step(0, 0, 0, 0, 0, 0); endtask
  task automatic coin(input int v);    step(1, v, 0, 0, 0, 0); endtask
  task automatic sel(input int it);    step(0, 0, 1, it, 0, 0); endtask
  task automatic do_cancel();          step(0, 0, 0, 0, 1, 0); endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_total"},  32'(total_currency),  0);
    check({tag, "_item"},   32'(item_selected),   0);
    check({tag, "_ramt"},   32'(refund_amount),   0);
    check({tag, "_accept"}, 32'(coin_accept),     0);
    check({tag, "_reject"}, 32'(coin_reject),     0);
    check({tag, "_refund"}, 32'(refund_valid),    0);
    check({tag, "_den"},    32'(dispense_enable), 0);
    check({tag, "_busy"},   32'(busy),            0);
  endtask

  initial begin
    bit cv, sv, can, dv;
    int val, it;

    // Reset state
    rstn = 1'b0;
    idle();
    idle();
    check_all_zero("reset");
    rstn = 1'b1;

    // Coins then successful dispense
    coin(20);
    check("t1_accept", 32'(coin_accept), 1);
    check("t1_total20", 32'(total_currency), 20);
    coin(20);
    coin(10);
    check("t1_total50", 32'(total_currency), 50);
    check("t1_model_pin", m_credit, 50);
    sel(10);
    check("t1_busy_req", 32'(busy), 1);
    check("t1_den_early", 32'(dispense_enable), 0);
    idle();
    check("t1_den", 32'(dispense_enable), 1);
    check("t1_item", 32'(item_selected), 10);
    check("t1_total_held", 32'(total_currency), 50);
    step(0, 0, 0, 0, 0, 1);
    check("t1_total_clr", 32'(total_currency), 0);
    check("t1_busy_done", 32'(busy), 0);
    check("t1_den_once", 32'(dispense_enable), 0);

    // Failed dispense, with a coin offered during REQUEST
    coin(20);
    sel(11);
    coin(5);
    check("t2_busy_coin_rej", 32'(coin_reject), 1);
    check("t2_total_kept", 32'(total_currency), 20);
    idle();
    idle();
    check("t2_back_collect", 32'(busy), 0);
    check("t2_total_after", 32'(total_currency), 20);
    check("t2_no_refund", 32'(refund_valid), 0);
    check("t2_item", 32'(item_selected), 11);
    do_cancel();
    idle();
    check("t2_refund", 32'(refund_valid), 1);
    check("t2_refund_amt", 32'(refund_amount), 20);

    // Overflow
    coin(100);
    coin(50);
    check("t3_ovf_reject", 32'(coin_reject), 1);
    check("t3_ovf_total", 32'(total_currency), 100);
    coin(27);
    check("t3_fill_accept", 32'(coin_accept), 1);
    check("t3_fill_total", 32'(total_currency), 127);
    do_cancel();
    idle();
    check("t3_refund_amt", 32'(refund_amount), 127);

    // Cancel with simultaneous coin
    coin(30);
    step(1, 10, 0, 0, 1, 0);
    check("t4_coin_reject", 32'(coin_reject), 1);
    check("t4_total_refund_state", 32'(total_currency), 30);
    idle();
    check("t4_refund", 32'(refund_valid), 1);
    check("t4_refund_amt", 32'(refund_amount), 30);
    check("t4_total_clr", 32'(total_currency), 0);
    idle();
    check("t4_refund_pulse", 32'(refund_valid), 0);
    check("t4_refund_hold", 32'(refund_amount), 30);

    // Timeout
    coin(5);
    repeat (8) idle();
    check("t5_not_yet", 32'(refund_valid), 0);
    idle();
    check("t5_refund", 32'(refund_valid), 1);
    check("t5_refund_amt", 32'(refund_amount), 5);

    // Coin at cycle 7 defers the timeout
    coin(5);
    repeat (6) idle();
    coin(1);
    check("t5b_total", 32'(total_currency), 6);
    repeat (2) idle();
    check("t5b_deferred", 32'(refund_valid), 0);
    repeat (6) idle();
    check("t5b_not_yet", 32'(refund_valid), 0);
    idle();
    check("t5b_refund", 32'(refund_valid), 1);
    check("t5b_refund_amt", 32'(refund_amount), 6);

    // Reset during WAIT
    coin(10);
    sel(3);
    idle();
    check("t6_in_wait", 32'(dispense_enable), 1);
    rstn = 1'b0;
    idle();
    check_all_zero("t6_rst");
    rstn = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 399) != 0);
      cv   = ($urandom_range(0, 2) == 0);
      val  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 70));
      sv   = ($urandom_range(0, 11) == 0);
      it   = int'($urandom_range(0, 1023));
      can  = ($urandom_range(0, 24) == 0);
      dv   = ($urandom_range(0, 3) == 0);
      if ((i % 200) >= 185) begin
        cv = 0; sv = 0; can = 0;
      end
      step(cv, val, sv, it, can, dv);
    end
    rstn = 1'b1;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_coin_collector

// File: doc/coin_collector.md
# coin_collector

Transaction front end that sits directly upstream of `output_logic` in the vending machine. It accepts coins and accumulates `total_currency`, latches the customer's item selection, and issues a one-cycle `dispense_enable` request. It watches `dispense_valid` for the result and refunds the credit on cancel or on inactivity timeout.

## Interface
- `CURRENCY_WIDTH`, 7, width of credit, coin and refund values; matches `output_logic`.
- `ITEM_ADDR_WIDTH`, 10, width of the item address.
- `TIMEOUT_CYCLES`, 1000, idle cycles in COLLECT before an automatic refund; must be ≥ 1.
- `RESP_WINDOW`, 2, cycles after `dispense_enable` during which `dispense_valid` is sampled; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `coin_valid`  in  1  one-cycle coin insertion strobe.
- `coin_value`  in  CURRENCY_WIDTH  value of the inserted coin; a value of 0 is rejected.
- `select_valid`  in  1  one-cycle selection strobe.
- `select_item`  in  ITEM_ADDR_WIDTH  requested item address.
- `cancel`  in  1  customer cancel strobe.
- `dispense_valid`  in  1  success indication from `output_logic`.
- `dispense_enable`  out  1  one-cycle dispense request to `output_logic`.
- `item_selected`  out  ITEM_ADDR_WIDTH  latched item address.
- `total_currency`  out  CURRENCY_WIDTH  accumulated credit.
- `coin_accept`  out  1  pulse: coin added to credit.
- `coin_reject`  out  1  pulse: coin returned to the customer.
- `refund_valid`  out  1  pulse: `refund_amount` is valid.
- `refund_amount`  out  CURRENCY_WIDTH  credit being returned.
- `busy`  out  1  high in REQUEST, WAIT and REFUND.

## Operation
- States: IDLE, COLLECT, REQUEST, WAIT, REFUND.
- **IDLE**
  - An accepted coin loads the credit and moves to COLLECT.
  - `select_valid` and `cancel` are ignored.
- **COLLECT**: priority is cancel > select > coin.
  - `cancel` → REFUND. A coin in the same cycle is rejected.
  - `select_valid` with credit > 0 → latch `select_item` and move to REQUEST. A coin in the same cycle is rejected.
  - Otherwise a coin adds to the credit.
  - Timer expiry → REFUND.
- **Coin arithmetic**
  - Compute `total + coin_value` at CURRENCY_WIDTH+1 bits.
  - If the sum exceeds 2^CURRENCY_WIDTH−1, or `coin_value` is 0, pulse `coin_reject` and leave the credit unchanged (no saturation, no wrap).
  - Otherwise pulse `coin_accept` and add the coin.
- **REQUEST**: drive `dispense_enable` for exactly 1 cycle, then go to WAIT.
- **WAIT**: lasts RESP_WINDOW cycles.
  - `dispense_valid` high in any cycle of the window → success. Clear credit to 0 (change is returned by `output_logic`) and go to IDLE.
  - Window elapses without `dispense_valid` → failure. Keep the credit, reload the timer and return to COLLECT.
- **REFUND**: pulse `refund_valid` with `refund_amount` = credit, clear credit, go to IDLE.
- **Coins outside IDLE/COLLECT**: `coin_valid` in REQUEST, WAIT or REFUND → `coin_reject`.
- **Inactivity timer**
  - Counts in COLLECT only.
  - Reloads on every accepted coin, on a failed dispense and on entry to COLLECT.
  - Expires after TIMEOUT_CYCLES consecutive cycles with no accepted coin.
- **Reset mid-transaction**: credit is discarded with no refund pulse (intended behaviour).

## Timing
- Reset values:
  - State is IDLE.
  - `dispense_enable`, `coin_accept`, `coin_reject`, `refund_valid` and `busy` are 0.
  - `total_currency`, `item_selected` and `refund_amount` are 0.
- All outputs are registered.
- Latencies:
  - `coin_accept` / `coin_reject` and the updated `total_currency` appear the cycle after `coin_valid`.
  - `dispense_enable` asserts 2 cycles after `select_valid`: one cycle to latch, then REQUEST.
  - `refund_valid` asserts 2 cycles after `cancel`.
  - Timer expiry → `refund_valid` takes 2 cycles.
- `item_selected` and `total_currency` are held stable from REQUEST entry until WAIT exits, so `output_logic` samples consistent values.
- `refund_amount` holds its value after the pulse until the next refund.

## Structure
- Shared package `vend_pkg` holds:
  - the `coll_state_t` enum;
  - default `CURRENCY_WIDTH` and `ITEM_ADDR_WIDTH` constants, shared with `output_logic`.
- Sub-module `inactivity_timer`:
  - inputs: `clk`, `rstn`, `enable`, `reload`;
  - output: `expired`;
  - counter width $clog2(TIMEOUT_CYCLES+1).
- Everything else (FSM, credit adder/compare, latches) lives in `coin_collector`.

## Test plan
- **Coins then successful dispense**: coins 20, 20, 10 → `total_currency`=50. Select item 10 → one-cycle `dispense_enable` with `item_selected`=10 and total 50. `dispense_valid` in WAIT → total 0, state IDLE.
- **Failed dispense**: total 20, select item 11, no `dispense_valid` for RESP_WINDOW cycles → back to COLLECT with total still 20, no refund pulse.
- **Overflow**: total 100, coin 50 → `coin_reject`, total stays 100. Coin 27 → accepted, total 127.
- **Cancel with simultaneous coin**: total 30, `cancel` + coin 10 in the same cycle → `coin_reject`; `refund_valid` with `refund_amount`=30; total 0.
- **Timeout**: TIMEOUT_CYCLES=8, coin 5 then idle → `refund_valid` with amount 5 in the cycle timing given above. A coin at cycle 7 must reload the timer and defer the refund.
- **Reset and busy-time coins**: `rstn`=0 during WAIT → all outputs 0 the next cycle. Coin during REQUEST → `coin_reject`, credit unchanged.
